// File: rtl/round_controller.sv
// Game round sequencer: loads an expression per round, counts down ticks,
// judges the player's answer and keeps score and lives for the generator.
module round_controller #(
    parameter int unsigned ROUND_TIME = 9,
    parameter int unsigned LIVES      = 3,
    parameter int unsigned SCORE_MAX  = 99
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        tick,
    input  logic [11:0] gen_exp,
    input  logic [1:0]  gen_line,
    input  logic        ans_valid,
    input  logic [6:0]  ans,
    output logic [11:0] exp,
    output logic [1:0]  line,
    output logic [6:0]  score,
    output logic [1:0]  lives,
    output logic [3:0]  time_left,
    output logic        playing,
    output logic        game_over,
    output logic        hit,
    output logic        miss
);

    localparam logic [3:0] RT = 4'(ROUND_TIME);
    localparam logic [1:0] LV = 2'(LIVES);
    localparam logic [6:0] SM = 7'(SCORE_MAX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_JUDGE,
        S_OVER
    } state_t;

    state_t      state, state_n;
    logic [11:0] exp_n;
    logic [1:0]  line_n;
    logic [6:0]  score_n;
    logic [1:0]  lives_n;
    logic [3:0]  time_n;
    logic        playing_n, over_n, hit_n, miss_n;
    logic [6:0]  expect_q, expect_n;
    logic        op_ok_q, op_ok_n;

    // Expected answer for an expression; non-arithmetic ops return 0 and are
    // rejected separately through op_ok.
    function automatic logic [6:0] calc_answer(input logic [11:0] e);
        logic [3:0] n1, op, n2;
        logic [6:0] r;
        n1 = e[11:8];
        op = e[7:4];
        n2 = e[3:0];
        r  = '0;
        case (op)
            4'hA: r = {3'b000, n1} + {3'b000, n2};
            4'hB: r = (n1 >= n2) ? {3'b000, n1 - n2} : {3'b000, n2 - n1};
            4'hC: r = 7'({4'b0000, n1} * {4'b0000, n2});
            4'hD: r = (n2 == 4'd0) ? 7'd0 : {3'b000, n1 / n2};
            default: r = '0;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            exp       <= '0;
            line      <= '0;
            score     <= '0;
            lives     <= '0;
            time_left <= '0;
            playing   <= 1'b0;
            game_over <= 1'b0;
            hit       <= 1'b0;
            miss      <= 1'b0;
            expect_q  <= '0;
            op_ok_q   <= 1'b0;
        end else begin
            state     <= state_n;
            exp       <= exp_n;
            line      <= line_n;
            score     <= score_n;
            lives     <= lives_n;
            time_left <= time_n;
            playing   <= playing_n;
            game_over <= over_n;
            hit       <= hit_n;
            miss      <= miss_n;
            expect_q  <= expect_n;
            op_ok_q   <= op_ok_n;
        end
    end

    always_comb begin
        state_n   = state;
        exp_n     = exp;
        line_n    = line;
        score_n   = score;
        lives_n   = lives;
        time_n    = time_left;
        playing_n = playing;
        over_n    = game_over;
        hit_n     = 1'b0;
        miss_n    = 1'b0;
        expect_n  = expect_q;
        op_ok_n   = op_ok_q;

        case (state)
            S_IDLE, S_OVER: begin
                if (start) begin
                    state_n   = S_LOAD;
                    score_n   = '0;
                    lives_n   = LV;
                    playing_n = 1'b1;
                    over_n    = 1'b0;
                end
            end
            S_LOAD: begin
                state_n  = S_WAIT;
                exp_n    = gen_exp;
                line_n   = (gen_line == 2'd3) ? 2'd0 : gen_line;
                time_n   = RT;
                expect_n = calc_answer(gen_exp);
                op_ok_n  = (gen_exp[7:4] >= 4'hA) && (gen_exp[7:4] <= 4'hD);
            end
            S_WAIT: begin
                // An answer arriving with a tick takes priority; the tick is dropped.
                if (ans_valid) begin
                    state_n = S_JUDGE;
                    hit_n   = op_ok_q && (ans == expect_q);
                    miss_n  = !(op_ok_q && (ans == expect_q));
                end else if (tick) begin
                    if (time_left <= 4'd1) begin
                        time_n  = '0;
                        state_n = S_JUDGE;
                        miss_n  = 1'b1;
                    end else begin
                        time_n = time_left - 4'd1;
                    end
                end
            end
            S_JUDGE: begin
                if (hit) begin
                    if (score < SM) begin
                        score_n = score + 7'd1;
                    end
                    state_n = S_LOAD;
                end else if (lives <= 2'd1) begin
                    lives_n   = '0;
                    time_n    = '0;
                    playing_n = 1'b0;
                    over_n    = 1'b1;
                    state_n   = S_OVER;
                end else begin
                    lives_n = lives - 2'd1;
                    state_n = S_LOAD;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule
